mem_bridge: RTL and testbench

- Parametrised data-side system bridge between the MEM pipeline stage and N memory-mapped devices plus data memory.
- Decodes the MEM-stage address into DM or device windows, gates write enables, and muxes read data back.
- Adds multi-cycle device access with a ready handshake, pipeline stall, timeout, and bus-error reporting, replacing single-cycle combinational DM/device steering.

---
 rtl/mem_bridge_pkg.sv | 25 ++
 rtl/mem_bridge_decode.sv | 36 +++
 rtl/mem_bridge.sv | 177 +++++++++++++++++
 tb/tb_mem_bridge.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the MEM-stage data bridge: FSM encoding,
// data-memory region tags and default device window layout.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Wide enough for up to 8 device channels.
  localparam int DEV_IDX_W = 3;

  localparam logic [18:0] DM_LO_TAG  = 19'h00000;
  localparam logic [19:0] DM_HI_PAGE = 20'h00002;

  localparam logic [63:0] DEF_DEV_BASE = {32'h00007F10, 32'h00007F00};
  localparam logic [31:0] DEF_DEV_MASK = 32'hFFFFFFF0;

  function automatic logic [7:0] onehot8(input logic [DEV_IDX_W-1:0] idx);
    onehot8 = 8'h01 << idx;
  endfunction

endpackage

// File: rtl/mem_bridge_decode.sv
// Combinational address decoder: data memory wins over devices, and among
// overlapping device windows the lowest index wins.
module mem_bridge_decode
  import mem_bridge_pkg::*;
#(
  parameter int                   NDEV     = 2,
  parameter logic [NDEV*32-1:0]   DEV_BASE = DEF_DEV_BASE,
  parameter logic [31:0]          DEV_MASK = DEF_DEV_MASK
) (
  input  logic [31:0]          cpu_addr,
  output logic                 dm_hit,
  output logic                 dev_hit,
  output logic [DEV_IDX_W-1:0] dev_idx,
  output logic                 unmapped
);

  logic w_dev_any;

  // Scan from the top so the lowest matching window is the last to assign.
  always_comb begin
    w_dev_any = 1'b0;
    dev_idx   = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if ((cpu_addr & DEV_MASK) == DEV_BASE[i*32 +: 32]) begin
        w_dev_any = 1'b1;
        dev_idx   = DEV_IDX_W'(i);
      end else begin
        w_dev_any = w_dev_any;
      end
    end
    dm_hit   = (cpu_addr[31:13] == DM_LO_TAG) || (cpu_addr[31:12] == DM_HI_PAGE);
    dev_hit  = ~dm_hit & w_dev_any;
    unmapped = ~dm_hit & ~w_dev_any;
  end

endmodule

// File: rtl/mem_bridge.sv
// MEM-stage data bridge: zero-latency data memory path plus multi-cycle
// device accesses with ready handshake, pipeline stall, timeout and bus error.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int                 NDEV     = 2,
  parameter logic [NDEV*32-1:0] DEV_BASE = DEF_DEV_BASE,
  parameter logic [31:0]        DEV_MASK = DEF_DEV_MASK,
  parameter int                 TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [3:0]           cpu_be,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_stall,
  output logic                 cpu_err,
  output logic                 dm_we,
  output logic [3:0]           dm_be,
  input  logic [31:0]          dm_rdata,
  output logic [NDEV-1:0]      dev_sel,
  output logic                 dev_we,
  output logic [31:0]          dev_addr,
  output logic [31:0]          dev_wdata,
  input  logic [NDEV*32-1:0]   dev_rdata,
  input  logic [NDEV-1:0]      dev_ready
);

  localparam int              CW     = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [CW-1:0]   TO_VAL = CW'(TIMEOUT);

  state_e                 r_state;
  state_e                 w_next;
  logic [31:0]            r_addr;
  logic [31:0]            r_wdata;
  logic [31:0]            r_rdata;
  logic                   r_we;
  logic [DEV_IDX_W-1:0]   r_idx;
  logic [CW-1:0]          r_cnt;

  logic                   w_dm_hit;
  logic                   w_dev_hit;
  logic                   w_unmapped;
  logic [DEV_IDX_W-1:0]   w_dev_idx;
  logic                   w_sel_ready;
  logic [31:0]            w_sel_rdata;
  logic [7:0]             w_onehot;

  mem_bridge_decode #(
    .NDEV     (NDEV),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK)
  ) u_decode (
    .cpu_addr (cpu_addr),
    .dm_hit   (w_dm_hit),
    .dev_hit  (w_dev_hit),
    .dev_idx  (w_dev_idx),
    .unmapped (w_unmapped)
  );

  assign dm_be     = cpu_be;
  assign dev_addr  = r_addr;
  assign dev_wdata = r_wdata;
  assign w_onehot  = onehot8(r_idx);

  // Pick the ready/read-data slice of the latched device; others are ignored.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = 32'h0;
    for (int i = 0; i < NDEV; i++) begin
      if (r_idx == DEV_IDX_W'(i)) begin
        w_sel_ready = dev_ready[i];
        w_sel_rdata = dev_rdata[i*32 +: 32];
      end else begin
        w_sel_ready = w_sel_ready;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_next    = r_state;
    cpu_stall = 1'b0;
    cpu_err   = 1'b0;
    cpu_rdata = 32'h0;
    dm_we     = 1'b0;
    dev_sel   = '0;
    dev_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req && w_dm_hit) begin
          dm_we     = cpu_we;
          cpu_rdata = cpu_we ? 32'h0 : dm_rdata;
        end else if (cpu_req && w_dev_hit) begin
          w_next    = ST_ACC;
          cpu_stall = 1'b1;
        end else if (cpu_req && w_unmapped) begin
          w_next    = ST_ERR;
          cpu_stall = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ACC: begin
        dev_sel   = w_onehot[NDEV-1:0];
        dev_we    = r_we;
        cpu_stall = 1'b1;
        // Ready beats timeout when both land in the same cycle.
        if (w_sel_ready) begin
          w_next = ST_DONE;
        end else if (r_cnt == TO_VAL) begin
          w_next = ST_ERR;
        end else begin
          w_next = ST_ACC;
        end
      end
      ST_DONE: begin
        cpu_rdata = r_rdata;
        w_next    = ST_IDLE;
      end
      ST_ERR: begin
        cpu_err = 1'b1;
        w_next  = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Access latches, wait counter and captured read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_req && w_dev_hit) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_we    <= cpu_we;
            r_idx   <= w_dev_idx;
            r_cnt   <= '0;
          end
        end
        ST_ACC: begin
          if (w_sel_ready) begin
            r_rdata <= r_we ? 32'h0 : w_sel_rdata;
          end else if (r_cnt != {CW{1'b1}}) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge with a small byte-enabled DM model.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_err, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic [1:0]  dev_sel;
  logic        dev_we;
  logic [31:0] dev_addr, dev_wdata;
  logic [63:0] dev_rdata;
  logic [1:0]  dev_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] dm_mem [0:1023];

  always #5 clk = ~clk;

  mem_bridge dut (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .dm_we(dm_we), .dm_be(dm_be), .dm_rdata(dm_rdata), .dev_sel(dev_sel),
    .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_rdata(dev_rdata), .dev_ready(dev_ready)
  );

  assign dm_rdata = dm_mem[cpu_addr[11:2]];

  always @(posedge clk) begin
    if (dm_we) begin
      for (int b = 0; b < 4; b++) begin
        if (dm_be[b]) dm_mem[cpu_addr[11:2]][b*8 +: 8] <= cpu_wdata[b*8 +: 8];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_be = 4'b1111;
  endtask

  task automatic test_reset();
    mid();
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    n_checks++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", cpu_err); end
    n_checks++; if (dev_sel !== 2'b00) begin n_fail++; $display("FAIL reset_sel: got %b want 00", dev_sel); end
    n_checks++; if (dev_we !== 1'b0) begin n_fail++; $display("FAIL reset_dev_we: got %b want 0", dev_we); end
    n_checks++; if (dev_addr !== 32'h0) begin n_fail++; $display("FAIL reset_dev_addr: got %h want 0", dev_addr); end
    n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
    reset_n = 1'b1;
  endtask

  task automatic test_dm();
    next_cycle(); drive(1'b1, 1'b1, 32'h00001004, 32'hDEADBEEF);
    mid();
    n_checks++; if (dm_we !== 1'b1) begin n_fail++; $display("FAIL dm_store_we: got %b want 1", dm_we); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL dm_store_stall: got %b want 0", cpu_stall); end
    n_checks++; if (dev_sel !== 2'b00) begin n_fail++; $display("FAIL dm_store_sel: got %b want 00", dev_sel); end
    n_checks++; if (dm_be !== 4'b1111) begin n_fail++; $display("FAIL dm_store_be: got %b want 1111", dm_be); end
    next_cycle(); drive(1'b1, 1'b0, 32'h00001004, 32'h0);
    mid();
    n_checks++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL dm_load_data: got %h want deadbeef", cpu_rdata); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL dm_load_stall: got %b want 0", cpu_stall); end
    n_checks++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL dm_load_we: got %b want 0", dm_we); end
    // Upper DM page 0x2xxx is also data memory.
    next_cycle(); drive(1'b1, 1'b1, 32'h00002008, 32'h0BADF00D);
    mid();
    n_checks++; if (dm_we !== 1'b1) begin n_fail++; $display("FAIL dm_page2_we: got %b want 1", dm_we); end
    next_cycle(); drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_dev_load();
    next_cycle(); drive(1'b1, 1'b0, 32'h00007F04, 32'h0);
    dev_rdata = {32'hAAAA5555, 32'h12345678}; dev_ready = 2'b00;
    mid();
    n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL load_idle_stall: got %b want 1", cpu_stall); end
    n_checks++; if (dev_sel !== 2'b00) begin n_fail++; $display("FAIL load_idle_sel: got %b want 00", dev_sel); end
    next_cycle(); dev_ready = 2'b01;
    mid();
    n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL load_acc_stall: got %b want 1", cpu_stall); end
    n_checks++; if (dev_sel !== 2'b01) begin n_fail++; $display("FAIL load_acc_sel: got %b want 01", dev_sel); end
    n_checks++; if (dev_we !== 1'b0) begin n_fail++; $display("FAIL load_acc_we: got %b want 0", dev_we); end
    n_checks++; if (dev_addr !== 32'h00007F04) begin n_fail++; $display("FAIL load_acc_addr: got %h want 00007f04", dev_addr); end
    next_cycle(); dev_ready = 2'b00;
    mid();
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL load_done_stall: got %b want 0", cpu_stall); end
    n_checks++; if (cpu_rdata !== 32'h12345678) begin n_fail++; $display("FAIL load_done_data: got %h want 12345678", cpu_rdata); end
    n_checks++; if (dev_sel !== 2'b00) begin n_fail++; $display("FAIL load_done_sel: got %b want 00", dev_sel); end
    next_cycle(); drive(1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    n_checks++; if (dev_sel !== 2'b00 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL load_no_restart: got sel=%b stall=%b want 00/0", dev_sel, cpu_stall); end
  endtask

  task automatic test_dev_store_wait();
    int stalls = 0;
    int bad    = 0;
    next_cycle(); drive(1'b1, 1'b1, 32'h00007F14, 32'hCAFEF00D); dev_ready = 2'b00;
    mid();
    if (cpu_stall === 1'b1) stalls++;
    for (int k = 1; k <= 4; k++) begin
      next_cycle(); dev_ready = (k == 4) ? 2'b10 : 2'b00;
      mid();
      if (cpu_stall === 1'b1) stalls++;
      if (dev_we !== 1'b1 || dev_sel !== 2'b10) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL store_acc_we_sel: got %0d bad cycles want 0", bad); end
    n_checks++; if (dev_addr !== 32'h00007F14) begin n_fail++; $display("FAIL store_addr: got %h want 00007f14", dev_addr); end
    n_checks++; if (dev_wdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL store_wdata: got %h want cafef00d", dev_wdata); end
    next_cycle(); dev_ready = 2'b00;
    mid();
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL store_done_stall: got %b want 0", cpu_stall); end
    n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL store_done_rdata: got %h want 0", cpu_rdata); end
    n_checks++; if (stalls != 5) begin n_fail++; $display("FAIL store_stall_count: got %0d want 5", stalls); end
    next_cycle(); drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_timeout();
    int acc = 0;
    int bad = 0;
    next_cycle(); drive(1'b1, 1'b0, 32'h00007F00, 32'h0);
    dev_ready = 2'b10; dev_rdata = {32'h11111111, 32'h22222222};
    mid();
    for (int k = 0; k < 40; k++) begin
      next_cycle(); mid();
      if (cpu_stall === 1'b1) begin
        acc++;
        if (dev_sel !== 2'b01) bad++;
      end else begin
        break;
      end
    end
    n_checks++; if (acc != 16) begin n_fail++; $display("FAIL timeout_acc_cycles: got %0d want 16", acc); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL timeout_sel: got %0d bad cycles want 0", bad); end
    n_checks++; if (cpu_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", cpu_err); end
    n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_rdata: got %h want 0", cpu_rdata); end
    n_checks++; if (dev_sel !== 2'b00) begin n_fail++; $display("FAIL timeout_err_sel: got %b want 00", dev_sel); end
    next_cycle(); drive(1'b0, 1'b0, 32'h0, 32'h0); dev_ready = 2'b00;
    mid();
    n_checks++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_pulse: got %b want 0", cpu_err); end
  endtask

  task automatic test_ready_at_timeout();
    int bad = 0;
    next_cycle(); drive(1'b1, 1'b0, 32'h00007F08, 32'h0);
    dev_ready = 2'b00; dev_rdata = {32'h0, 32'h5A5A1234};
    mid();
    for (int k = 1; k <= 16; k++) begin
      next_cycle(); dev_ready = (k == 16) ? 2'b01 : 2'b00;
      mid();
      if (cpu_stall !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL edge_acc_stall: got %0d bad cycles want 0", bad); end
    next_cycle(); dev_ready = 2'b00;
    mid();
    n_checks++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL edge_ready_wins_err: got %b want 0", cpu_err); end
    n_checks++; if (cpu_rdata !== 32'h5A5A1234) begin n_fail++; $display("FAIL edge_ready_wins_data: got %h want 5a5a1234", cpu_rdata); end
    next_cycle(); drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_unmapped();
    next_cycle(); drive(1'b1, 1'b1, 32'h00005000, 32'h77777777);
    mid();
    n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL unmapped_stall: got %b want 1", cpu_stall); end
    n_checks++; if (dm_we !== 1'b0 || dev_we !== 1'b0) begin n_fail++; $display("FAIL unmapped_we: got dm=%b dev=%b want 0/0", dm_we, dev_we); end
    next_cycle();
    mid();
    n_checks++; if (cpu_err !== 1'b1) begin n_fail++; $display("FAIL unmapped_err: got %b want 1", cpu_err); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL unmapped_err_stall: got %b want 0", cpu_stall); end
    n_checks++; if (dm_we !== 1'b0 || dev_we !== 1'b0) begin n_fail++; $display("FAIL unmapped_err_we: got dm=%b dev=%b want 0/0", dm_we, dev_we); end
    next_cycle(); drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid();
    next_cycle(); drive(1'b1, 1'b1, 32'h00007F14, 32'h13572468); dev_ready = 2'b00;
    next_cycle();
    mid();
    n_checks++; if (dev_sel !== 2'b10) begin n_fail++; $display("FAIL rstmid_pre_sel: got %b want 10", dev_sel); end
    #2;
    cpu_req = 1'b0; reset_n = 1'b0;
    #1;
    n_checks++; if (dev_sel !== 2'b00) begin n_fail++; $display("FAIL rstmid_sel: got %b want 00", dev_sel); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", cpu_stall); end
    n_checks++; if (dev_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_dev_we: got %b want 0", dev_we); end
    mid();
    reset_n = 1'b1;
    next_cycle(); drive(1'b1, 1'b0, 32'h00001004, 32'h0);
    mid();
    n_checks++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rstmid_dm_data: got %h want deadbeef", cpu_rdata); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_dm_stall: got %b want 0", cpu_stall); end
    next_cycle(); drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) dm_mem[i] = 32'h0;
    reset_n   = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    dev_rdata = 64'h0;
    dev_ready = 2'b00;
    test_reset();
    test_dm();
    test_dev_load();
    test_dev_store_wait();
    test_timeout();
    test_ready_at_timeout();
    test_unmapped();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
